// File: rtl/branch_hazard_ctrl.sv
// Branch resolution sequencer in ID. It stalls on operand hazards and turns the resolver outcome into a PC redirect plus an IF/ID flush.
// Latency: stall, redirect and flush are combinational in the current cycle. Statistics and stall_err update at the next edge.
// Backpressure: hold freezes all state and forces the four control outputs low. rst overrides hold.
module branch_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             id_branch,
  input  logic [5:0]       id_branch_code,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dest,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic             stall_front,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_err
);

  // stall_run saturates one step past MAX_STALL, which is enough to keep the watchdog condition true.
  localparam int               RUN_W   = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] stall_run, stall_run_d;
  logic             uses_rt, code_valid;
  logic             rs_haz, rt_haz, hazard;
  logic             stall_evt, resolve_evt, taken_evt, err_set;

  // Decode: known branch codes, and the two-source compares that also read rt.
  always_comb begin
    uses_rt    = 1'b0;
    code_valid = 1'b0;
    case (id_branch_code)
      6'h03, 6'h04:                begin code_valid = 1'b1; uses_rt = 1'b1; end
      6'h07, 6'h0F, 6'h11, 6'h13:  code_valid = 1'b1;
      default:                     ;
    endcase
  end

  // Hazard: a used, non-zero source register is still being produced by EX (ALU or load) or by a MEM load.
  always_comb begin
    rs_haz = (id_rs != 5'd0) &&
             (((ex_reg_write || ex_mem_read) && (ex_dest == id_rs)) ||
              (mem_mem_read && (mem_dest == id_rs)));
    rt_haz = uses_rt && (id_rt != 5'd0) &&
             (((ex_reg_write || ex_mem_read) && (ex_dest == id_rt)) ||
              (mem_mem_read && (mem_dest == id_rt)));
    hazard = rs_haz || rt_haz;
  end

  // Next-state logic and per-cycle stall/resolve events. hold and rst suppress all events.
  always_comb begin
    state_d     = state_q;
    stall_run_d = stall_run;
    stall_evt   = 1'b0;
    resolve_evt = 1'b0;
    if (!hold && !rst) begin
      case (state_q)
        IDLE: begin
          if (id_branch && hazard) begin
            state_d     = STALL;
            stall_run_d = RUN_W'(1);
            stall_evt   = 1'b1;
          end else if (id_branch) begin
            resolve_evt = 1'b1;
          end
        end
        STALL: begin
          if (!id_branch) begin
            // The stalled branch was squashed upstream, so it is dropped without being counted.
            state_d     = IDLE;
            stall_run_d = '0;
          end else if (hazard) begin
            stall_evt = 1'b1;
            if (stall_run != RUN_SAT) stall_run_d = stall_run + RUN_W'(1);
          end else begin
            state_d     = IDLE;
            stall_run_d = '0;
            resolve_evt = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          stall_run_d = '0;
        end
      endcase
    end
    taken_evt = resolve_evt && code_valid && branch_taken;
    err_set   = stall_evt && (int'(stall_run_d) > MAX_STALL);
  end

  // Control outputs. An unknown code resolves as not taken, so it never redirects.
  always_comb begin
    stall_front = stall_evt;
    bubble_ex   = stall_evt;
    pc_redirect = taken_evt;
    flush_ifid  = taken_evt;
    pc_target   = taken_evt ? branch_target : 32'd0;
  end

  // FSM state, stall run length and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      stall_run <= '0;
      stall_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_run <= stall_run_d;
      if (err_set) stall_err <= 1'b1;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (resolve_evt && (branch_cnt != '1)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (taken_evt   && (taken_cnt  != '1)) taken_cnt  <= taken_cnt  + CNT_W'(1);
      if (stall_evt   && (stall_cnt  != '1)) stall_cnt  <= stall_cnt  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl. It runs a default-size instance and a narrow one (3-bit counters, MAX_STALL=1) on shared stimulus.
// Latency: outputs are compared at the falling edge. The reference model advances at the rising edge.
// Backpressure: hold is driven randomly and directly. Nothing in the bench waits on a DUT event.
module tb_branch_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hold, id_branch, ex_reg_write, ex_mem_read, mem_mem_read, branch_taken;
  logic [5:0]  id_branch_code;
  logic [4:0]  id_rs, id_rt, ex_dest, mem_dest;
  logic [31:0] branch_target;

  logic        sf0, bx0, fl0, pr0, se0;
  logic [31:0] pt0;
  logic [15:0] bc0, tc0, sc0;
  logic        sf1, bx1, fl1, pr1, se1;
  logic [31:0] pt1;
  logic [2:0]  bc1, tc1, sc1;

  branch_hazard_ctrl u0 (
    .clk(clk), .rst(rst), .hold(hold), .id_branch(id_branch), .id_branch_code(id_branch_code),
    .id_rs(id_rs), .id_rt(id_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_dest(ex_dest), .mem_mem_read(mem_mem_read), .mem_dest(mem_dest),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall_front(sf0), .bubble_ex(bx0), .flush_ifid(fl0), .pc_redirect(pr0), .pc_target(pt0),
    .branch_cnt(bc0), .taken_cnt(tc0), .stall_cnt(sc0), .stall_err(se0));

  branch_hazard_ctrl #(.CNT_W(3), .MAX_STALL(1)) u1 (
    .clk(clk), .rst(rst), .hold(hold), .id_branch(id_branch), .id_branch_code(id_branch_code),
    .id_rs(id_rs), .id_rt(id_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_dest(ex_dest), .mem_mem_read(mem_mem_read), .mem_dest(mem_dest),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall_front(sf1), .bubble_ex(bx1), .flush_ifid(fl1), .pc_redirect(pr1), .pc_target(pt1),
    .branch_cnt(bc1), .taken_cnt(tc1), .stall_cnt(sc1), .stall_err(se1));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_br[2], m_tk[2], m_st[2], m_run[2];
  bit m_err[2];

  function automatic int max_stall(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int cnt_max(input int i);   return (i == 0) ? 65535 : 7; endfunction

  function automatic bit busy(input logic [4:0] r);
    return (r != 0) && ((((ex_reg_write || ex_mem_read) && ex_dest == r)) || (mem_mem_read && mem_dest == r));
  endfunction

  function automatic bit known_code();
    return id_branch_code inside {6'h03, 6'h04, 6'h07, 6'h0F, 6'h11, 6'h13};
  endfunction

  function automatic bit m_hazard();
    return busy(id_rs) || ((id_branch_code inside {6'h03, 6'h04}) && busy(id_rt));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_br[i] = 0; m_tk[i] = 0; m_st[i] = 0; m_run[i] = 0; m_err[i] = 0;
      end else if (!hold) begin
        if (id_branch && m_hazard()) begin
          if (m_st[i] < cnt_max(i)) m_st[i]++;
          m_run[i]++;
          if (m_run[i] > max_stall(i)) m_err[i] = 1;
        end else if (id_branch) begin
          if (m_br[i] < cnt_max(i)) m_br[i]++;
          if (branch_taken && known_code() && m_tk[i] < cnt_max(i)) m_tk[i]++;
          m_run[i] = 0;
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input logic sf, input logic bx, input logic fl, input logic pr,
                          input logic [31:0] pt, input logic [15:0] bc, input logic [15:0] tc,
                          input logic [15:0] sc, input logic se);
    bit live, e_stall, e_redir;
    live    = !rst && !hold && id_branch;
    e_stall = live && m_hazard();
    e_redir = live && !m_hazard() && branch_taken && known_code();
    chk($sformatf("u%0d.stall_front", i), {31'd0, sf}, {31'd0, e_stall});
    chk($sformatf("u%0d.bubble_ex", i),   {31'd0, bx}, {31'd0, e_stall});
    chk($sformatf("u%0d.flush_ifid", i),  {31'd0, fl}, {31'd0, e_redir});
    chk($sformatf("u%0d.pc_redirect", i), {31'd0, pr}, {31'd0, e_redir});
    chk($sformatf("u%0d.pc_target", i),   pt, e_redir ? branch_target : 32'd0);
    chk($sformatf("u%0d.branch_cnt", i),  {16'd0, bc}, m_br[i]);
    chk($sformatf("u%0d.taken_cnt", i),   {16'd0, tc}, m_tk[i]);
    chk($sformatf("u%0d.stall_cnt", i),   {16'd0, sc}, m_st[i]);
    chk($sformatf("u%0d.stall_err", i),   {31'd0, se}, {31'd0, m_err[i]});
  endtask

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, sf0, bx0, fl0, pr0, pt0, bc0, tc0, sc0, se0);
      cmp_inst(1, sf1, bx1, fl1, pr1, pt1, {13'd0, bc1}, {13'd0, tc1}, {13'd0, sc1}, se1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic set_idle();
    hold = 0; id_branch = 0; id_branch_code = 6'h00; id_rs = 0; id_rt = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_dest = 0; mem_mem_read = 0; mem_dest = 0;
    branch_taken = 0; branch_target = 32'd0;
  endtask

  task automatic set_br(input logic [5:0] code, input logic [4:0] rs, input logic [4:0] rt,
                        input logic tk, input logic [31:0] tgt);
    id_branch = 1; id_branch_code = code; id_rs = rs; id_rt = rt;
    branch_taken = tk; branch_target = tgt;
  endtask

  logic [5:0] codes [6];

  initial begin
    codes[0] = 6'h03; codes[1] = 6'h04; codes[2] = 6'h07;
    codes[3] = 6'h0F; codes[4] = 6'h11; codes[5] = 6'h13;
    set_idle();
    rst = 1;
    repeat (2) tick();
    chk_en = 1;
    rst = 0;
    @(negedge clk);
    chk("reset_branch_cnt", {16'd0, bc0}, 0);
    chk("reset_stall_err", {31'd0, se0}, 0);
    chk("reset_redirect", {31'd0, pr0}, 0);

    // BEQ r3,r4, no hazard, taken: redirect in the same cycle.
    tick(); set_br(6'h03, 5'd3, 5'd4, 1'b1, 32'h40);
    @(negedge clk);
    chk("t1_redirect", {31'd0, pr0}, 1); chk("t1_flush", {31'd0, fl0}, 1);
    chk("t1_target", pt0, 32'h40);       chk("t1_stall", {31'd0, sf0}, 0);
    tick(); set_idle();
    @(negedge clk);
    chk("t1_branch_cnt", {16'd0, bc0}, 1); chk("t1_taken_cnt", {16'd0, tc0}, 1);
    chk("t1_stall_cnt", {16'd0, sc0}, 0);

    // BNE rs=r5 behind a load in EX: two stalls, then resolve.
    tick(); set_br(6'h04, 5'd5, 5'd9, 1'b0, 32'h80); ex_mem_read = 1; ex_dest = 5'd5;
    @(negedge clk); chk("t2_stall1", {31'd0, sf0}, 1); chk("t2_bubble1", {31'd0, bx0}, 1);
    tick(); ex_mem_read = 0; mem_mem_read = 1; mem_dest = 5'd5;
    @(negedge clk); chk("t2_stall2", {31'd0, sf0}, 1);
    tick(); mem_mem_read = 0;
    @(negedge clk); chk("t2_resolve_nostall", {31'd0, sf0}, 0);
    tick(); set_idle();
    @(negedge clk);
    chk("t2_stall_cnt", {16'd0, sc0}, 2); chk("t2_branch_cnt", {16'd0, bc0}, 2);

    // r0 never hazards; BLEZ does not read rt.
    tick(); set_br(6'h0F, 5'd0, 5'd0, 1'b1, 32'h100); ex_reg_write = 1; ex_dest = 5'd0;
    @(negedge clk); chk("t3_r0_stall", {31'd0, sf0}, 0); chk("t3_r0_target", pt0, 32'h100);
    tick(); set_br(6'h07, 5'd2, 5'd7, 1'b0, 32'h0); ex_reg_write = 1; ex_dest = 5'd7;
    @(negedge clk); chk("t3_rt_unused", {31'd0, sf0}, 0);
    tick(); set_idle();
    @(negedge clk); chk("t3_branch_cnt", {16'd0, bc0}, 4);

    // A stall frozen by hold for 3 cycles, then resumed.
    tick(); set_br(6'h03, 5'd6, 5'd1, 1'b0, 32'h0); ex_reg_write = 1; ex_dest = 5'd6;
    @(negedge clk); chk("t4_stall", {31'd0, sf0}, 1);
    tick(); hold = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_stall", {31'd0, sf0}, 0);
      chk("t4_hold_cnt", {16'd0, sc0}, 3);
      tick();
    end
    hold = 0;
    @(negedge clk); chk("t4_resume", {31'd0, sf0}, 1); chk("t4_resume_cnt", {16'd0, sc0}, 3);
    tick(); ex_reg_write = 0;
    tick(); set_idle();
    @(negedge clk); chk("t4_stall_cnt", {16'd0, sc0}, 4); chk("t4_branch_cnt", {16'd0, bc0}, 5);

    // Watchdog on the MAX_STALL=1 instance: three hazard cycles.
    rst = 1;
    tick(); rst = 0;
    set_br(6'h03, 5'd8, 5'd0, 1'b0, 32'h0); ex_reg_write = 1; ex_dest = 5'd8;
    @(negedge clk); chk("t5_err_c1", {31'd0, se1}, 0);
    tick(); @(negedge clk); chk("t5_err_c2", {31'd0, se1}, 0);
    tick(); @(negedge clk); chk("t5_err_c3", {31'd0, se1}, 1); chk("t5_err_big", {31'd0, se0}, 0);
    tick(); ex_reg_write = 0;
    @(negedge clk); chk("t5_err_resolve", {31'd0, se1}, 1);
    tick(); set_idle();
    @(negedge clk); chk("t5_err_sticky", {31'd0, se1}, 1); chk("t5_stall_cnt", {29'd0, sc1}, 3);

    // Reset in the middle of a stall; the pending branch starts over.
    tick(); set_br(6'h03, 5'd8, 5'd0, 1'b0, 32'h0); ex_reg_write = 1; ex_dest = 5'd8;
    tick(); rst = 1;
    @(negedge clk); chk("t6_rst_stall", {31'd0, sf0}, 0);
    tick(); rst = 0;
    @(negedge clk);
    chk("t6_branch_cnt", {16'd0, bc0}, 0); chk("t6_stall_cnt", {16'd0, sc0}, 0);
    chk("t6_err0", {31'd0, se0}, 0);       chk("t6_err1", {31'd0, se1}, 0);
    chk("t6_restall", {31'd0, sf0}, 1);
    tick(); ex_reg_write = 0;
    tick(); set_br(6'h03, 5'd3, 5'd4, 1'b1, 32'h200);
    // Nine taken branches saturate the 3-bit counters.
    repeat (9) tick();
    set_idle();
    @(negedge clk);
    chk("t6_sat_taken", {29'd0, tc1}, 7); chk("t6_sat_branch", {29'd0, bc1}, 7);
    chk("t6_wide_branch", {16'd0, bc0}, 10); chk("t6_wide_taken", {16'd0, tc0}, 9);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst          = ($urandom_range(0, 199) == 0);
      hold         = ($urandom_range(0, 7) == 0);
      id_branch    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        id_branch_code = 6'($urandom);
        id_rs          = 5'd0;
      end else begin
        id_branch_code = codes[$urandom_range(0, 5)];
        id_rs          = 5'($urandom_range(0, 7));
      end
      id_rt         = 5'($urandom_range(0, 7));
      ex_reg_write  = ($urandom_range(0, 2) == 0);
      ex_mem_read   = ($urandom_range(0, 4) == 0);
      ex_dest       = 5'($urandom_range(0, 7));
      mem_mem_read  = ($urandom_range(0, 4) == 0);
      mem_dest      = 5'($urandom_range(0, 7));
      branch_taken  = 1'($urandom);
      branch_target = $urandom;
    end
    tick(); set_idle();
    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
